// File: rtl/controle_limiares_sensor.sv
// controle_limiares_sensor: scans N sensor channels against a high/low limit pair
// through one shared 8.8 comparator and keeps per-channel debounced alarms.
// Ports: clock/reset (async, active-low); iniciar starts a scan; valores packs
// channel k in [16k+15:16k]; limite_max/limite_min are the limits; alarme_alto/
// alarme_baixo are per-channel alarms; ocupado marks a scan in progress; pronto
// pulses at scan end; erro_config flags min > max at the last accepted start.
module comparador_float_sensor (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        gt,
    output logic        lt
);
    // integer byte sits in the MSBs, so plain unsigned order is 8.8 order
    assign gt = a > b;
    assign lt = a < b;
endmodule

module controle_limiares_sensor #(
    parameter int N_CANAIS = 4,
    parameter int DEBOUNCE = 3
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    iniciar,
    input  logic [16*N_CANAIS-1:0]  valores,
    input  logic [15:0]             limite_max,
    input  logic [15:0]             limite_min,
    output logic [N_CANAIS-1:0]     alarme_alto,
    output logic [N_CANAIS-1:0]     alarme_baixo,
    output logic                    ocupado,
    output logic                    pronto,
    output logic                    erro_config
);
    localparam int IW = N_CANAIS > 1 ? $clog2(N_CANAIS) : 1;
    localparam logic [3:0] DEB = 4'(DEBOUNCE);
    localparam logic [IW-1:0] ULTIMO = IW'(N_CANAIS - 1);

    typedef enum logic [1:0] {OCIOSO, CMP_MAX, CMP_MIN, FIM} estado_t;

    estado_t                estado_q, estado_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [16*N_CANAIS-1:0] snap_val_q, snap_val_d;
    logic [15:0]            snap_max_q, snap_max_d, snap_min_q, snap_min_d;
    logic                   acima_q, acima_d, erro_q, erro_d;
    logic [3:0]             cnt_alto_q [N_CANAIS];
    logic [3:0]             cnt_alto_d [N_CANAIS];
    logic [3:0]             cnt_baixo_q [N_CANAIS];
    logic [3:0]             cnt_baixo_d [N_CANAIS];
    logic [N_CANAIS-1:0]    alto_q, alto_d, baixo_q, baixo_d;
    logic [15:0]            canal, op_a, op_b;
    logic                   gt, lt;

    assign canal = snap_val_q[{idx_q, 4'b0000} +: 16];
    // idle: check limit consistency (min vs max); scanning: channel vs selected limit
    assign op_a = estado_q == OCIOSO ? limite_min : canal;
    assign op_b = estado_q == OCIOSO ? limite_max : estado_q == CMP_MAX ? snap_max_q : snap_min_q;

    comparador_float_sensor u_cmp (
        .a  (op_a),
        .b  (op_b),
        .gt (gt),
        .lt (lt)
    );

    always_comb begin
        estado_d    = estado_q;
        idx_d       = idx_q;
        snap_val_d  = snap_val_q;
        snap_max_d  = snap_max_q;
        snap_min_d  = snap_min_q;
        acima_d     = acima_q;
        erro_d      = erro_q;
        cnt_alto_d  = cnt_alto_q;
        cnt_baixo_d = cnt_baixo_q;
        alto_d      = alto_q;
        baixo_d     = baixo_q;
        case (estado_q)
            OCIOSO: if (iniciar) begin
                snap_val_d = valores;
                snap_max_d = limite_max;
                snap_min_d = limite_min;
                idx_d      = '0;
                erro_d     = gt;
                estado_d   = gt ? FIM : CMP_MAX;
            end
            CMP_MAX: begin
                acima_d  = gt;
                estado_d = CMP_MIN;
            end
            CMP_MIN: begin
                for (int k = 0; k < N_CANAIS; k++) begin
                    if (idx_q == IW'(k)) begin
                        cnt_alto_d[k]  = !acima_q ? 4'd0 : cnt_alto_q[k] == DEB ? DEB : cnt_alto_q[k] + 4'd1;
                        cnt_baixo_d[k] = !lt ? 4'd0 : cnt_baixo_q[k] == DEB ? DEB : cnt_baixo_q[k] + 4'd1;
                        alto_d[k]      = cnt_alto_d[k] == DEB;
                        baixo_d[k]     = cnt_baixo_d[k] == DEB;
                    end
                end
                estado_d = idx_q == ULTIMO ? FIM : CMP_MAX;
                idx_d    = idx_q == ULTIMO ? idx_q : idx_q + 1'b1;
            end
            default: estado_d = OCIOSO;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q   <= OCIOSO;
            idx_q      <= '0;
            snap_val_q <= '0;
            snap_max_q <= '0;
            snap_min_q <= '0;
            acima_q    <= 1'b0;
            erro_q     <= 1'b0;
            alto_q     <= '0;
            baixo_q    <= '0;
            for (int k = 0; k < N_CANAIS; k++) begin
                cnt_alto_q[k]  <= 4'd0;
                cnt_baixo_q[k] <= 4'd0;
            end
        end else begin
            estado_q    <= estado_d;
            idx_q       <= idx_d;
            snap_val_q  <= snap_val_d;
            snap_max_q  <= snap_max_d;
            snap_min_q  <= snap_min_d;
            acima_q     <= acima_d;
            erro_q      <= erro_d;
            alto_q      <= alto_d;
            baixo_q     <= baixo_d;
            cnt_alto_q  <= cnt_alto_d;
            cnt_baixo_q <= cnt_baixo_d;
        end
    end

    assign alarme_alto  = alto_q;
    assign alarme_baixo = baixo_q;
    assign ocupado      = estado_q != OCIOSO;
    assign pronto       = estado_q == FIM;
    assign erro_config  = erro_q;
endmodule

// File: tb/tb_controle_limiares_sensor.sv
// tb_controle_limiares_sensor: directed checks of scan latency, debounce, limits and start/reset rules.
module tb_controle_limiares_sensor;
    localparam logic [15:0] NOM  = 16'h1900;
    localparam logic [15:0] MAXL = 16'h1E00;
    localparam logic [15:0] MINL = 16'h0A00;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        iniciar = 1'b0;
    logic [63:0] valores = {4{NOM}};
    logic [15:0] limite_max = MAXL;
    logic [15:0] limite_min = MINL;
    logic [3:0]  alarme_alto, alarme_baixo;
    logic        ocupado, pronto, erro_config;
    int          n_cmp = 0;
    int          n_err = 0;
    int          edges, np;

    controle_limiares_sensor #(.N_CANAIS(4), .DEBOUNCE(3)) dut (
        .clock        (clock),
        .reset        (reset),
        .iniciar      (iniciar),
        .valores      (valores),
        .limite_max   (limite_max),
        .limite_min   (limite_min),
        .alarme_alto  (alarme_alto),
        .alarme_baixo (alarme_baixo),
        .ocupado      (ocupado),
        .pronto       (pronto),
        .erro_config  (erro_config)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // counts edges after the start edge until pronto is seen; 40 means it never came
    task automatic wait_pronto(input int e0, output int e);
        e = e0;
        while (e < 40) begin
            @(negedge clock);
            if (pronto) break;
            @(posedge clock);
            e++;
        end
    endtask

    task automatic scan(input logic [63:0] v, input logic [15:0] mx, input logic [15:0] mn, output int e);
        @(negedge clock);
        valores = v;
        limite_max = mx;
        limite_min = mn;
        iniciar = 1'b1;
        @(posedge clock);
        #1 iniciar = 1'b0;
        wait_pronto(0, e);
    endtask

    task automatic count_pronto(input int cycles, output int n);
        n = 0;
        repeat (cycles) begin
            @(negedge clock);
            if (pronto) n++;
        end
    endtask

    initial begin
        #2 reset = 1'b0;
        repeat (2) @(negedge clock);
        check("rst_alto", alarme_alto, 0);
        check("rst_baixo", alarme_baixo, 0);
        check("rst_ocupado", ocupado, 0);
        check("rst_pronto", pronto, 0);
        check("rst_erro", erro_config, 0);
        reset = 1'b1;

        scan({4{NOM}}, MAXL, MINL, edges);
        check("nom_lat", edges, 8);
        check("nom_alto", alarme_alto, 0);
        check("nom_baixo", alarme_baixo, 0);
        check("nom_erro", erro_config, 0);
        @(negedge clock);
        check("nom_pulse", pronto, 0);
        check("nom_idle", ocupado, 0);

        for (int s = 1; s <= 3; s++) begin
            scan({NOM, 16'h1E01, NOM, NOM}, MAXL, MINL, edges);
            check($sformatf("deb_lat%0d", s), edges, 8);
            check($sformatf("deb_alto%0d", s), alarme_alto, s == 3 ? 4'b0100 : 4'b0000);
        end
        scan({NOM, MAXL, NOM, NOM}, MAXL, MINL, edges);
        check("deb_eq_clear", alarme_alto, 0);

        for (int s = 1; s <= 3; s++) begin
            scan({16'h09FF, NOM, 16'h0B00, 16'h0A00}, MAXL, 16'h0A01, edges);
            check($sformatf("frac_baixo%0d", s), alarme_baixo, s == 3 ? 4'b1001 : 4'b0000);
        end
        for (int s = 1; s <= 3; s++) begin
            scan({NOM, NOM, 16'h0B00, NOM}, MAXL, 16'h0AFF, edges);
            check($sformatf("frac_ff%0d", s), alarme_baixo, 0);
        end

        for (int s = 1; s <= 3; s++)
            scan({NOM, NOM, NOM, 16'h1E01}, MAXL, MINL, edges);
        check("pre_alto", alarme_alto, 4'b0001);

        scan({4{NOM}}, 16'h1000, 16'h2000, edges);
        check("cfg_lat", edges, 0);
        check("cfg_erro", erro_config, 1);
        check("cfg_alto", alarme_alto, 4'b0001);
        check("cfg_baixo", alarme_baixo, 0);
        repeat (3) @(negedge clock);
        check("cfg_hold", erro_config, 1);
        check("cfg_idle", ocupado, 0);
        scan({NOM, NOM, NOM, 16'h1E01}, MAXL, MINL, edges);
        check("cfg_clear", erro_config, 0);
        check("cfg_sat", alarme_alto, 4'b0001);
        scan({4{NOM}}, MAXL, MINL, edges);
        check("cfg_alto_clr", alarme_alto, 0);

        for (int s = 1; s <= 2; s++)
            scan({NOM, NOM, 16'h1E01, NOM}, MAXL, MINL, edges);
        check("busy_pre", alarme_alto, 0);
        @(negedge clock);
        valores = {NOM, NOM, 16'h1E01, NOM};
        iniciar = 1'b1;
        @(posedge clock);
        #1 iniciar = 1'b0;
        repeat (2) @(posedge clock);
        #1 begin
            valores = {4{NOM}};
            limite_max = 16'h0100;
            iniciar = 1'b1;
        end
        @(posedge clock);
        #1 iniciar = 1'b0;
        wait_pronto(3, edges);
        check("busy_lat", edges, 8);
        check("busy_snap", alarme_alto, 4'b0010);
        count_pronto(12, np);
        check("busy_single", np, 0);
        check("busy_idle", ocupado, 0);

        limite_max = MAXL;
        @(negedge clock);
        valores = {NOM, NOM, 16'h1E01, NOM};
        iniciar = 1'b1;
        @(posedge clock);
        #1 iniciar = 1'b0;
        repeat (4) @(posedge clock);
        #1 reset = 1'b0;
        #1 begin
            check("arst_alto", alarme_alto, 0);
            check("arst_ocupado", ocupado, 0);
            check("arst_pronto", pronto, 0);
        end
        #3 reset = 1'b1;
        count_pronto(15, np);
        check("arst_nopronto", np, 0);
        for (int s = 1; s <= 3; s++) begin
            scan({NOM, NOM, 16'h1E01, NOM}, MAXL, MINL, edges);
            check($sformatf("arst_deb%0d", s), alarme_alto, s == 3 ? 4'b0010 : 4'b0000);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
